lsu_mem_ctrl: RTL
=================

Name: lsu_mem_ctrl

Overview:
- Load/store unit sitting between the EX/MEM pipeline boundary and the data SRAM port.
- Consumes the controller's registered `is_load_ex`/`is_store_ex` encodings plus EX address/data.
- Runs a req/ready handshake to memory, generates byte-lane write enables and sign/zero-extended load data, and stalls the pipeline while an access is outstanding.

Parameters:
- ADDR_W, 14, word-address width of the data memory port.
- TIMEOUT_CYCLES, 64, cycles in ACCESS without mem_ready before abort (only with LSU_TIMEOUT_EN).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- is_load_ex  in  3  000 none, 001 LB, 010 LH, 011 LW/FLW, 100 LHU, 101 LBU
- is_store_ex  in  2  00 none, 01 SW, 10 SH, 11 SB
- float_wb_en_ex  in  1  load targets the float register file
- rd_addr_ex  in  5  load destination register
- addr_ex  in  32  effective byte address
- store_data_ex  in  32  rs2 data for stores
- mem_req  out  1  access request, held until mem_ready
- mem_web  out  4  per-byte write enable, active low; 4'hF for reads
- mem_addr  out  ADDR_W  word address = latched addr[ADDR_W+1:2]
- mem_wdata  out  32  lane-aligned store data
- mem_rdata  in  32  read data, valid with mem_ready
- mem_ready  in  1  access complete this cycle
- stall  out  1  freeze IF/ID/EX
- load_valid  out  1  one-cycle pulse, load_data valid
- load_data  out  32  formatted load result
- load_rd  out  5  destination of load_data
- load_float  out  1  load_data goes to the float register file
- misalign_err  out  1  one-cycle pulse on a misaligned request
- bus_err  out  1  one-cycle pulse on timeout abort (0 when feature off)

Behaviour:
- States: IDLE, ACCESS, RESP.
- Reset value of all outputs is 0, except `mem_web` = 4'hF. State returns to IDLE; the timeout counter clears.
  - Reset mid-ACCESS drops `mem_req` immediately (asynchronous) and discards the access.
- new_req = (is_load_ex != 0) | (is_store_ex != 0); sampled in IDLE or RESP.
  - If both are nonzero, the store wins and the load is ignored.
- Misaligned request: LW with addr[1:0] != 0, or LH/LHU/SH with addr[0] != 0.
  - `misalign_err` pulses the next cycle.
  - No memory access; state goes to / stays IDLE; `stall` is not asserted.
- Aligned request at cycle T: latch type, addr, data, rd and float; go to ACCESS at T+1.
- ACCESS:
  - `mem_req` = 1; `mem_addr`, `mem_web` and `mem_wdata` are driven from latched values and stay stable until mem_ready.
  - On mem_ready, a store goes to IDLE and a load captures mem_rdata and goes to RESP.
- RESP (one cycle):
  - `load_valid` = 1; `load_data`, `load_rd` and `load_float` are valid.
  - A new request in this cycle is accepted exactly as in IDLE.
- Minimum load latency is 3 cycles, request to load_valid, when mem_ready is high on the first ACCESS cycle. A store occupies 2 cycles.
- stall = (new_req & aligned & state != ACCESS) | (state == ACCESS & !mem_ready).
  - Combinational; drops in the cycle mem_ready is seen.
- Store lanes:
  - SW: web = 0000, wdata = data.
  - SH: web = 1100 if addr[1] = 0, else 0011; wdata = {2{data[15:0]}}.
  - SB: web bit addr[1:0] = 0, others 1; wdata = {4{data[7:0]}}.
- Load format, with the byte/halfword selected by latched addr[1:0]/addr[1]:
  - LB and LH sign-extend.
  - LBU and LHU zero-extend.
  - LW passes the word through.
- `load_data` holds its last value when load_valid = 0.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - A counter increments in each ACCESS cycle without mem_ready.
  - On reaching TIMEOUT_CYCLES-1, the access aborts: `mem_req` drops, `bus_err` pulses for 1 cycle, state goes to IDLE, and `load_valid` is not asserted.
  - The counter clears on leaving ACCESS.
- Undefined: no counter; ACCESS waits indefinitely; `bus_err` is tied to 0.

Test Plan:
- Store SB, then load LBU:
  - SB: addr=0x103, data=0x000000A5, mem_ready immediate -> mem_web=0111, mem_wdata=0xA5A5A5A5, mem_addr=0x40, stall high 1 cycle.
  - LBU from 0x103 with mem_rdata=0xA5000000 -> load_valid at T+2, load_data=0x000000A5.
- LB from 0x101, mem_rdata=0x0000F000 -> load_data=0xFFFFFFF0; LH from 0x102, mem_rdata=0x80010000 -> load_data=0xFFFF8001.
- LW, mem_ready delayed 5 cycles -> mem_req/mem_addr stable for 5 cycles, stall high through them, load_valid 1 cycle after mem_ready, load_rd/load_float match the request.
- LW at 0x102 and SH at 0x001 -> misalign_err pulse each, mem_req never asserted, stall 0.
- Back-to-back LW then SW with the SW presented in the RESP cycle -> load_valid and new acceptance in the same cycle; the SW issues with web=0000.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=8, mem_ready held 0 -> bus_err after 8 ACCESS cycles, then IDLE, no load_valid. Asserting rst mid-ACCESS drops mem_req immediately.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store unit between the EX/MEM boundary and the data SRAM.
// It latches an EX load or store, runs a req/ready handshake to memory,
// aligns store lanes and formats load data, and stalls the front end while
// an access is outstanding.
// Optional: define LSU_TIMEOUT_EN to abort accesses that wait TIMEOUT_CYCLES
// cycles without mem_ready and report them on bus_err.
module lsu_mem_ctrl #(
  parameter int ADDR_W         = 14,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        is_load_ex,
  input  logic [1:0]        is_store_ex,
  input  logic              float_wb_en_ex,
  input  logic [4:0]        rd_addr_ex,
  input  logic [31:0]       addr_ex,
  input  logic [31:0]       store_data_ex,
  output logic              mem_req,
  output logic [3:0]        mem_web,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              stall,
  output logic              load_valid,
  output logic [31:0]       load_data,
  output logic [4:0]        load_rd,
  output logic              load_float,
  output logic              misalign_err,
  output logic              bus_err
);

  localparam logic [2:0] LD_LB = 3'b001, LD_LH = 3'b010, LD_LW = 3'b011,
                         LD_LHU = 3'b100, LD_LBU = 3'b101;
  localparam logic [1:0] ST_SW = 2'b01, ST_SH = 2'b10, ST_SB = 2'b11;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state;

  logic [2:0]  ld_q;     // latched load type, 0 when the access is a store
  logic [1:0]  off_q;    // latched byte offset for load formatting
  logic [4:0]  rd_q;
  logic        flt_q;

  logic        is_st, is_ld, new_req, misaligned;
  logic [3:0]  lane_web;
  logic [31:0] lane_wdata;
  logic [31:0] fmt_data;
  logic        unused_bits;

  assign unused_bits = ^addr_ex[31:ADDR_W+2];

  // Request decode: a store beats a simultaneous load.
  always_comb begin
    is_st      = (is_store_ex != 2'b00);
    is_ld      = !is_st && (is_load_ex != 3'b000);
    new_req    = is_st || is_ld;
    misaligned = 1'b0;
    if (is_st)
      misaligned = (is_store_ex == ST_SH) && addr_ex[0];
    else if (is_ld)
      misaligned = ((is_load_ex == LD_LW) && (addr_ex[1:0] != 2'b00)) ||
                   (((is_load_ex == LD_LH) || (is_load_ex == LD_LHU)) && addr_ex[0]);
  end

  // New work is only taken outside ACCESS; ACCESS holds until memory answers.
  assign stall = (new_req && !misaligned && (state != ACCESS)) ||
                 ((state == ACCESS) && !mem_ready);

  // Store lane steering: replicate data, enable only the addressed bytes.
  always_comb begin
    lane_web   = 4'hF;
    lane_wdata = store_data_ex;
    case (is_store_ex)
      ST_SW: lane_web = 4'b0000;
      ST_SH: begin
        lane_wdata = {2{store_data_ex[15:0]}};
        lane_web   = addr_ex[1] ? 4'b0011 : 4'b1100;
      end
      ST_SB: begin
        lane_wdata              = {4{store_data_ex[7:0]}};
        lane_web[addr_ex[1:0]]  = 1'b0;
      end
      default: ;
    endcase
  end

  // Load formatting: pick byte/half by latched offset, then extend.
  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    case (off_q)
      2'd0:    b = mem_rdata[7:0];
      2'd1:    b = mem_rdata[15:8];
      2'd2:    b = mem_rdata[23:16];
      default: b = mem_rdata[31:24];
    endcase
    h = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (ld_q)
      LD_LB:   fmt_data = {{24{b[7]}}, b};
      LD_LBU:  fmt_data = {24'h0, b};
      LD_LH:   fmt_data = {{16{h[15]}}, h};
      LD_LHU:  fmt_data = {16'h0, h};
      default: fmt_data = mem_rdata;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] to_cnt;
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYCLES == 0);
  assign bus_err    = 1'b0;
`endif

  // Access FSM with registered memory and response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      mem_req      <= 1'b0;
      mem_web      <= 4'hF;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      load_valid   <= 1'b0;
      load_data    <= '0;
      load_rd      <= '0;
      load_float   <= 1'b0;
      misalign_err <= 1'b0;
      ld_q         <= '0;
      off_q        <= '0;
      rd_q         <= '0;
      flt_q        <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      bus_err      <= 1'b0;
      to_cnt       <= '0;
`endif
    end else begin
      load_valid   <= 1'b0;
      misalign_err <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      bus_err      <= 1'b0;
`endif
      case (state)
        ACCESS: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            mem_web <= 4'hF;
`ifdef LSU_TIMEOUT_EN
            to_cnt  <= '0;
`endif
            if (ld_q != 3'b000) begin
              load_data  <= fmt_data;
              load_rd    <= rd_q;
              load_float <= flt_q;
              load_valid <= 1'b1;
              state      <= RESP;
            end else begin
              state <= IDLE;
            end
          end
`ifdef LSU_TIMEOUT_EN
          else if (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            mem_req <= 1'b0;
            mem_web <= 4'hF;
            bus_err <= 1'b1;
            to_cnt  <= '0;
            state   <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        default: begin
          // IDLE and RESP accept new work identically.
          state <= IDLE;
          if (new_req) begin
            if (misaligned) begin
              misalign_err <= 1'b1;
            end else begin
              ld_q      <= is_st ? 3'b000 : is_load_ex;
              off_q     <= addr_ex[1:0];
              rd_q      <= rd_addr_ex;
              flt_q     <= float_wb_en_ex;
              mem_addr  <= addr_ex[ADDR_W+1:2];
              mem_web   <= is_st ? lane_web : 4'hF;
              mem_wdata <= lane_wdata;
              mem_req   <= 1'b1;
              state     <= ACCESS;
            end
          end
        end
      endcase
    end
  end

endmodule
